// File: rtl/armleobus_latency_responder_pkg.sv
// Shared definitions for the ARMLEOBUS latency responder: bus encodings,
// FSM state type and the fault-window address helper.
package armleobus_latency_responder_pkg;

    // ARMLEOBUS command encodings
    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;

    // ARMLEOBUS response encodings
    localparam logic [2:0] RESP_OKAY              = 3'd0;
    localparam logic [2:0] RESP_INVALID_OPERATION = 3'd1;
    localparam logic [2:0] RESP_UNKNOWN_ADDRESS   = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when base <= addr < base + nbytes. Widened to 36 bits so a
    // window that ends at the top of the 34-bit space cannot wrap.
    function automatic logic in_window(input logic [33:0] addr,
                                       input logic [33:0] base,
                                       input logic [35:0] nbytes);
        logic [35:0] a36;
        logic [35:0] b36;
        a36 = {2'b00, addr};
        b36 = {2'b00, base};
        return (a36 >= b36) && (a36 < (b36 + nbytes));
    endfunction

endpackage

// File: rtl/armleobus_sram_1rw.sv
// Single-port word SRAM with per-byte write enables and a registered read
// port. Contents are never reset; only the read register is.
module armleobus_sram_1rw #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            be_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [0:(1<<ADDR_WIDTH)-1];
    logic [31:0] rdata_q;

    // Byte-lane write; storage keeps its contents across reset
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Registered read, captured on the same edge as the access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/armleobus_latency_responder.sv
// ARMLEOBUS target backed by a word SRAM. The access happens on the
// acceptance edge; the response is then held back for LATENCY cycles
// before a single-cycle transaction_done pulse.
module armleobus_latency_responder
    import armleobus_latency_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [33:0] BASE_ADDR   = 34'h0,
    parameter int          LATENCY     = 2,
    parameter logic [33:0] FAULT_BASE  = 34'h0,
    parameter int          FAULT_WORDS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        transaction,
    input  logic [2:0]  cmd,
    input  logic [33:0] address,
    input  logic [31:0] wdata,
    input  logic [3:0]  wbyte_enable,
    output logic        transaction_done,
    output logic [2:0]  transaction_response,
    output logic [31:0] rdata,
    output logic        busy
);

    // Counter only has to hold LATENCY-2
    localparam int          CW          = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT  = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);
    localparam logic [35:0] FAULT_BYTES = 36'(FAULT_WORDS) << 2;

    logic [33:0]   offset;
    logic          is_read;
    logic          is_write;
    logic          in_range;
    logic          in_fault;
    logic          accept;
    logic          mem_en;
    logic [2:0]    resp_d;
    logic [31:0]   sram_rdata;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;
    logic          busy_q;
    logic          rd_ok_q;
    logic [2:0]    resp_q;

    assign offset   = address - BASE_ADDR;
    assign is_read  = (cmd == CMD_READ);
    assign is_write = (cmd == CMD_WRITE);
    // Compare before subtracting so addresses below the base never wrap in
    assign in_range = (address >= BASE_ADDR) && (offset[33:ADDR_WIDTH+2] == '0);
    assign in_fault = (FAULT_WORDS != 0) && in_window(address, FAULT_BASE, FAULT_BYTES);
    assign accept   = (state_q == ST_IDLE) && transaction;
    assign mem_en   = accept && (resp_d == RESP_OKAY);

    // Request decode, highest-priority error first
    always_comb begin
        resp_d = RESP_OKAY;
        if (!is_read && !is_write) begin
            resp_d = RESP_INVALID_OPERATION;
        end else if (offset[1:0] != 2'b00) begin
            resp_d = RESP_UNKNOWN_ADDRESS;
        end else if (!in_range) begin
            resp_d = RESP_UNKNOWN_ADDRESS;
        end else if (in_fault) begin
            resp_d = RESP_UNKNOWN_ADDRESS;
        end
    end

    armleobus_sram_1rw #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .clk     (clk),
        .rst     (rst),
        .en_i    (mem_en),
        .we_i    (is_write),
        .addr_i  (offset[ADDR_WIDTH+1:2]),
        .wdata_i (wdata),
        .be_i    (wbyte_enable),
        .rdata_o (sram_rdata)
    );

    // Accept / wait / done sequencing with registered bus outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rd_ok_q <= 1'b0;
            resp_q  <= RESP_OKAY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (transaction) begin
                        resp_q  <= resp_d;
                        rd_ok_q <= is_read && (resp_d == RESP_OKAY);
                        busy_q  <= 1'b1;
                        if (LATENCY <= 1) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // transaction is not looked at: a dropped request still completes
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign transaction_done     = done_q;
    assign transaction_response = resp_q;
    assign busy                 = busy_q;
    // Read data is only exposed for successful reads
    assign rdata                = rd_ok_q ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_armleobus_latency_responder.sv
// Bench for armleobus_latency_responder: four instances with different
// latency / depth / fault-window settings, directed steps plus random
// traffic checked against a behavioural memory model.
module tb_armleobus_latency_responder;

    localparam logic [2:0] C_NONE  = 3'd0;
    localparam logic [2:0] C_READ  = 3'd1;
    localparam logic [2:0] C_WRITE = 3'd2;
    localparam logic [2:0] R_OKAY  = 3'd0;
    localparam logic [2:0] R_INV   = 3'd1;
    localparam logic [2:0] R_UNK   = 3'd2;

    // unit 0: LAT2 depth1024, unit 1: fault window, unit 2: LAT1, unit 3: LAT5
    localparam int          LAT [4] = '{2, 2, 1, 5};
    localparam int          AW  [4] = '{10, 11, 10, 10};
    localparam logic [33:0] FB  [4] = '{34'h0, 34'h1000, 34'h0, 34'h0};
    localparam int          FW  [4] = '{0, 1, 0, 0};

    logic        clk;
    logic        rst;
    logic        trans_s [4];
    logic [2:0]  cmd_s   [4];
    logic [33:0] addr_s  [4];
    logic [31:0] wdata_s [4];
    logic [3:0]  be_s    [4];
    logic        done_s  [4];
    logic [2:0]  resp_s  [4];
    logic [31:0] rdata_s [4];
    logic        busy_s  [4];

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mdl [longint];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_u
        armleobus_latency_responder #(
            .ADDR_WIDTH  (AW[g]),
            .BASE_ADDR   (34'h0),
            .LATENCY     (LAT[g]),
            .FAULT_BASE  (FB[g]),
            .FAULT_WORDS (FW[g])
        ) u_dut (
            .clk                  (clk),
            .rst                  (rst),
            .transaction          (trans_s[g]),
            .cmd                  (cmd_s[g]),
            .address              (addr_s[g]),
            .wdata                (wdata_s[g]),
            .wbyte_enable         (be_s[g]),
            .transaction_done     (done_s[g]),
            .transaction_response (resp_s[g]),
            .rdata                (rdata_s[g]),
            .busy                 (busy_s[g])
        );
    end

    // ---------------- scoreboard / model ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint mkey(input int u, input longint word);
        return longint'(u) * 64'd1000000 + word;
    endfunction

    function automatic logic [2:0] exp_resp(input int u, input logic [2:0] c, input logic [33:0] a);
        longint ad;
        longint depth;
        longint fb;
        ad = longint'(a);
        depth = longint'(1) << AW[u];
        fb = longint'(FB[u]);
        if (c != C_READ && c != C_WRITE) return R_INV;
        if (ad % 4 != 0) return R_UNK;
        if (ad / 4 >= depth) return R_UNK;
        if (FW[u] != 0 && ad >= fb && ad < fb + 4 * longint'(FW[u])) return R_UNK;
        return R_OKAY;
    endfunction

    task automatic model_write(input int u, input logic [33:0] a, input logic [31:0] wd, input logic [3:0] be);
        longint k;
        logic [31:0] w;
        k = mkey(u, longint'(a) / 4);
        w = mdl.exists(k) ? mdl[k] : 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        end
        mdl[k] = w;
    endtask

    // ---------------- drivers ----------------
    // Called at a sample point (#1 after a rising edge). Holds the request
    // until the done pulse, measuring cycles from acceptance.
    task automatic do_txn(input int u, input logic [2:0] c, input logic [33:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          output logic [2:0] resp, output logic [31:0] rd,
                          output int lat, output bit seen);
        bit acc;
        int edges;
        logic pb;
        acc = 0; edges = 0; seen = 0; lat = 0; resp = 3'h7; rd = 32'h0;
        cmd_s[u] = c; addr_s[u] = a; wdata_s[u] = wd; be_s[u] = be;
        trans_s[u] = 1'b1;
        pb = busy_s[u];
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!acc) begin
                if (busy_s[u] && !pb) begin
                    acc = 1;
                    edges = 0;
                end
                pb = busy_s[u];
            end else begin
                edges++;
            end
            if (acc && done_s[u]) begin
                seen = 1;
                lat = edges + 1;
                resp = resp_s[u];
                rd = rdata_s[u];
                break;
            end
        end
        trans_s[u] = 1'b0;
        cmd_s[u] = C_NONE;
    endtask

    task automatic run_txn(input int u, input logic [2:0] c, input logic [33:0] a,
                           input logic [31:0] wd, input logic [3:0] be, input string tag);
        logic [2:0] resp;
        logic [31:0] rd;
        logic [2:0] er;
        int lat;
        bit seen;
        longint k;
        er = exp_resp(u, c, a);
        do_txn(u, c, a, wd, be, resp, rd, lat, seen);
        chk({tag, ".done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({tag, ".latency"}, 64'(lat), 64'(LAT[u]));
            chk({tag, ".resp"}, 64'(resp), 64'(er));
            if (er != R_OKAY) begin
                chk({tag, ".rdata_zero"}, 64'(rd), 64'h0);
            end else if (c == C_READ) begin
                k = mkey(u, longint'(a) / 4);
                if (mdl.exists(k)) chk({tag, ".rdata"}, 64'(rd), 64'(mdl[k]));
            end
        end
        if (er == R_OKAY && c == C_WRITE) model_write(u, a, wd, be);
        @(posedge clk); #1;
        chk({tag, ".done_one_cycle"}, 64'(done_s[u]), 64'd0);
    endtask

    // Request held continuously: done every LAT+1 cycles, busy low only in IDLE
    task automatic held_sweep(input int u);
        bit found;
        int per;
        per = LAT[u] + 1;
        found = 0;
        cmd_s[u] = C_READ; addr_s[u] = 34'h0; be_s[u] = 4'h0;
        trans_s[u] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done_s[u]) begin
                found = 1;
                break;
            end
        end
        chk($sformatf("held%0d.first_done", LAT[u]), 64'(found), 64'd1);
        if (found) begin
            for (int p = 0; p < 3 * per; p++) begin
                if (p > 0) begin
                    @(posedge clk); #1;
                end
                chk($sformatf("held%0d.done[%0d]", LAT[u], p), 64'(done_s[u]), 64'(p % per == 0));
                chk($sformatf("held%0d.busy[%0d]", LAT[u], p), 64'(busy_s[u]), 64'(p % per != 1));
            end
        end
        trans_s[u] = 1'b0;
        cmd_s[u] = C_NONE;
        repeat (LAT[u] + 3) @(posedge clk);
        #1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] old_word;
        logic [63:0] rr;
        logic [33:0] a;
        logic [2:0] c;
        logic pb;
        bit acc;
        bit seen;
        int r;

        rst = 1'b1;
        for (int u = 0; u < 4; u++) begin
            trans_s[u] = 1'b0; cmd_s[u] = C_NONE; addr_s[u] = '0;
            wdata_s[u] = '0; be_s[u] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 4; u++) begin
            chk($sformatf("reset.done%0d", u), 64'(done_s[u]), 64'd0);
            chk($sformatf("reset.busy%0d", u), 64'(busy_s[u]), 64'd0);
            chk($sformatf("reset.resp%0d", u), 64'(resp_s[u]), 64'(R_OKAY));
            chk($sformatf("reset.rdata%0d", u), 64'(rdata_s[u]), 64'h0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // basic write/read, byte enables, error decode on unit 0
        run_txn(0, C_WRITE, 34'h10, 32'hDEADBEEF, 4'hF, "wr_10");
        run_txn(0, C_READ,  34'h10, 32'h0,        4'h0, "rd_10");
        run_txn(0, C_WRITE, 34'h10, 32'h11223344, 4'b0101, "wr_be");
        run_txn(0, C_READ,  34'h10, 32'h0,        4'h0, "rd_be");
        chk("model_be", 64'(mdl[mkey(0, 4)]), 64'h00000000DE22BE44);
        run_txn(0, C_WRITE, 34'h10, 32'hFFFFFFFF, 4'h0, "wr_be0");
        run_txn(0, C_READ,  34'h10, 32'h0,        4'hF, "rd_be0");
        run_txn(0, C_READ,  34'h1002, 32'h0, 4'h0, "rd_unaligned");
        run_txn(0, C_READ,  34'h1000, 32'h0, 4'h0, "rd_oob");
        run_txn(0, C_READ,  34'h0FFC, 32'h0, 4'h0, "rd_last");
        run_txn(0, C_READ,  34'h3FFFFFFFC, 32'h0, 4'h0, "rd_top");
        run_txn(0, C_NONE,  34'h10, 32'h0, 4'h0, "cmd_none");
        run_txn(0, C_WRITE, 34'h1000, 32'h12345678, 4'hF, "wr_oob");

        // fault window on unit 1
        old_word = g_u[1].u_dut.u_sram.mem_q[1024];
        run_txn(1, C_WRITE, 34'h1000, 32'h55AA55AA, 4'hF, "fault_wr");
        chk("fault_peek", 64'(g_u[1].u_dut.u_sram.mem_q[1024]), 64'(old_word));
        run_txn(1, C_READ,  34'h1000, 32'h0, 4'h0, "fault_rd");
        run_txn(1, C_WRITE, 34'h1004, 32'hA5A5_0F0F, 4'hF, "fault_next_wr");
        run_txn(1, C_READ,  34'h1004, 32'h0, 4'h0, "fault_next_rd");
        run_txn(1, C_WRITE, 34'h0FFC, 32'h0BADF00D, 4'hF, "fault_prev_wr");
        run_txn(1, C_READ,  34'h0FFC, 32'h0, 4'h0, "fault_prev_rd");
        run_txn(1, C_READ,  34'h2000, 32'h0, 4'h0, "aw11_oob");

        // back-to-back held requests for LATENCY 1 and 5
        held_sweep(2);
        held_sweep(3);

        // request dropped during WAIT still completes
        cmd_s[3] = C_READ; addr_s[3] = 34'h40; trans_s[3] = 1'b1;
        pb = busy_s[3]; acc = 0;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(posedge clk); #1;
            acc = busy_s[3] && !pb;
            pb = busy_s[3];
        end
        trans_s[3] = 1'b0; cmd_s[3] = C_NONE;
        chk("drop.accepted", 64'(acc), 64'd1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = done_s[3];
        end
        chk("drop.done_seen", 64'(seen), 64'd1);
        chk("drop.resp", 64'(resp_s[3]), 64'(R_OKAY));
        @(posedge clk); #1;
        chk("drop.done_one_cycle", 64'(done_s[3]), 64'd0);

        // reset asserted while a write waits
        cmd_s[3] = C_WRITE; addr_s[3] = 34'h20; wdata_s[3] = 32'hCAFEF00D; be_s[3] = 4'hF;
        trans_s[3] = 1'b1;
        pb = busy_s[3]; acc = 0;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(posedge clk); #1;
            acc = busy_s[3] && !pb;
            pb = busy_s[3];
        end
        chk("rstwait.accepted", 64'(acc), 64'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        trans_s[3] = 1'b0; cmd_s[3] = C_NONE;
        chk("rstwait.done", 64'(done_s[3]), 64'd0);
        chk("rstwait.busy", 64'(busy_s[3]), 64'd0);
        chk("rstwait.resp", 64'(resp_s[3]), 64'(R_OKAY));
        chk("rstwait.rdata", 64'(rdata_s[3]), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done_s[3]) seen = 1;
        end
        chk("rstwait.no_done", 64'(seen), 64'd0);
        chk("rstwait.peek", 64'(g_u[3].u_dut.u_sram.mem_q[8]), 64'hCAFEF00D);
        model_write(3, 34'h20, 32'hCAFEF00D, 4'hF);
        run_txn(3, C_READ, 34'h20, 32'h0, 4'h0, "rstwait.after");

        // random traffic on unit 0 over a preloaded 16-word pool
        for (int w = 0; w < 16; w++) begin
            run_txn(0, C_WRITE, 34'(w * 4), $urandom, 4'hF, $sformatf("fill%0d", w));
        end
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 6)      a = 34'($urandom_range(0, 15) * 4);
            else if (r == 7) a = 34'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (r == 8) a = 34'h1000 + 34'($urandom_range(0, 255) * 4);
            else begin
                rr = {$urandom, $urandom};
                a = rr[33:0];
            end
            r = $urandom_range(0, 9);
            if (r <= 3)      c = C_READ;
            else if (r <= 7) c = C_WRITE;
            else if (r == 8) c = 3'($urandom_range(3, 7));
            else             c = C_NONE;
            run_txn(0, c, a, $urandom, 4'($urandom_range(0, 15)), $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
